// File: rtl/demod_sequencer.sv
// demod_sequencer: session controller for the backscatter demodulator.
//
// Qualifies carrier on the envelope, gates the demodulator's working input for one
// packet, collects per-symbol decisions in a small bit FIFO and streams them out with
// valid/ready. A session closes on symbol limit, inter-symbol timeout or abort, then a
// guard period passes before carrier can be qualified again.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   enable                level; 0 blocks new sessions and aborts a running one
//   carrier               synchronised envelope detect
//   demod_flag/ctg/scheme demodulator decision strobe, decided bit, current scheme
//   working               demodulator working input (high in RUN)
//   bit_data/valid/ready  FIFO head stream
//   busy                  session in progress (not IDLE)
//   sym_count             symbols captured in current/last session
//   scheme_out            scheme latched at the first flag of a session
//   done, err_timeout     close pulse, and its timeout qualifier
//   overflow              sticky: a flag arrived with the FIFO full
//   scheme_err            scheme-change pulse (lock build only)
//
// Build option: define DEMOD_SEQ_SCHEME_LOCK_EN to abort the session when a flag
// reports a scheme different from the one latched at the first flag.
module demod_sequencer #(
   parameter int unsigned DETECT_CYC  = 20,
   parameter int unsigned MAX_SYMS    = 64,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned GUARD_CYC   = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned CNT_W       = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             carrier,
   input  logic             demod_flag,
   input  logic             demod_ctg,
   input  logic [1:0]       demod_scheme,
   output logic             working,
   output logic             bit_data,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             busy,
   output logic [CNT_W-1:0] sym_count,
   output logic [1:0]       scheme_out,
   output logic             done,
   output logic             err_timeout,
   output logic             overflow,
   output logic             scheme_err
);

   localparam int unsigned QW = $clog2(DETECT_CYC + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GW = $clog2(GUARD_CYC + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = PW + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StGuard} state_e;

   state_e           state_q, state_d;
   logic [QW-1:0]    qual_q, qual_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [GW-1:0]    guard_q, guard_d;
   logic [CNT_W-1:0] sym_q, sym_d;
   logic [1:0]       scheme_q, scheme_d;
   logic             have_q, have_d;     // scheme latched this session
   logic             ovf_q, ovf_d;
   logic             cause_q, cause_d;   // session closed by timeout
   logic             serr_q, serr_d;

   logic             mem_q [FIFO_DEPTH];
   logic [PW-1:0]    rd_q, wr_q;
   logic [OW-1:0]    occ_q;

   logic fifo_empty, fifo_full, pop, push, run_flag, accept, mismatch;

   assign fifo_empty = (occ_q == '0);
   assign fifo_full  = (occ_q == OW'(FIFO_DEPTH));
   assign bit_valid  = !fifo_empty;
   assign bit_data   = bit_valid ? mem_q[rd_q] : 1'b0;
   assign pop        = bit_valid && bit_ready;
   assign run_flag   = (state_q == StRun) && demod_flag;

`ifdef DEMOD_SEQ_SCHEME_LOCK_EN
   assign mismatch = run_flag && have_q && (demod_scheme != scheme_q);
`else
   assign mismatch = 1'b0;
`endif

   assign accept = run_flag && !mismatch;
   // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
   assign push   = accept && (!fifo_full || pop);

   always_comb begin
      state_d     = state_q;
      qual_d      = qual_q;
      tmo_d       = tmo_q;
      guard_d     = guard_q;
      sym_d       = sym_q;
      scheme_d    = scheme_q;
      have_d      = have_q;
      ovf_d       = ovf_q;
      cause_d     = cause_q;
      serr_d      = 1'b0;
      done        = 1'b0;
      err_timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable && carrier) begin
               if (qual_q == QW'(DETECT_CYC - 1)) begin
                  state_d = StRun;
                  qual_d  = '0;
                  sym_d   = '0;
                  tmo_d   = '0;
                  ovf_d   = 1'b0;
                  have_d  = 1'b0;
                  cause_d = 1'b0;
               end else begin
                  qual_d = qual_q + QW'(1);
               end
            end else begin
               qual_d = '0;
            end
         end
         StRun: begin
            if (accept) begin
               sym_d = sym_q + CNT_W'(1);
               tmo_d = '0;
               if (!have_q) begin
                  scheme_d = demod_scheme;
                  have_d   = 1'b1;
               end
               if (fifo_full && !pop) ovf_d = 1'b1;
            end else if (!demod_flag) begin
               tmo_d = tmo_q + TW'(1);
            end
            serr_d = mismatch;
            if (accept && (sym_q == CNT_W'(MAX_SYMS - 1))) begin
               state_d = StDrain;
            end else if (!enable || mismatch) begin
               state_d = StDrain;
            end else if (!demod_flag && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
               state_d = StDrain;
               cause_d = 1'b1;
            end
         end
         StDrain: begin
            if (fifo_empty) begin
               done        = 1'b1;
               err_timeout = cause_q;
               guard_d     = '0;
               state_d     = StGuard;
            end
         end
         StGuard: begin
            if (guard_q == GW'(GUARD_CYC - 1)) begin
               state_d = StIdle;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         qual_q   <= '0;
         tmo_q    <= '0;
         guard_q  <= '0;
         sym_q    <= '0;
         scheme_q <= '0;
         have_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cause_q  <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         qual_q   <= qual_d;
         tmo_q    <= tmo_d;
         guard_q  <= guard_d;
         sym_q    <= sym_d;
         scheme_q <= scheme_d;
         have_q   <= have_d;
         ovf_q    <= ovf_d;
         cause_q  <= cause_d;
         serr_q   <= serr_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 1'b0;
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= demod_ctg;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop) rd_q <= rd_q + PW'(1);
         if (push && !pop) begin
            occ_q <= occ_q + OW'(1);
         end else if (!push && pop) begin
            occ_q <= occ_q - OW'(1);
         end
      end
   end

   assign working    = (state_q == StRun);
   assign busy       = (state_q != StIdle);
   assign sym_count  = sym_q;
   assign scheme_out = scheme_q;
   assign overflow   = ovf_q;
   assign scheme_err = serr_q;

endmodule

// File: tb/tb_demod_sequencer.sv
// tb_demod_sequencer: self-checking bench for demod_sequencer.
// Session vectors are table-driven; decided bits go through a scoreboard queue that is
// filled as flags are driven and drained as the DUT hands bits downstream.
module tb_demod_sequencer;

   localparam int unsigned DETECT_CYC  = 20;
   localparam int unsigned MAX_SYMS    = 64;
   localparam int unsigned TIMEOUT_CYC = 1000;
   localparam int unsigned GUARD_CYC   = 8;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned CNT_W       = 7;

   logic             clock = 1'b0;
   logic             reset, enable, carrier, demod_flag, demod_ctg, bit_ready;
   logic [1:0]       demod_scheme;
   logic             working, bit_data, bit_valid, busy, done, err_timeout, overflow;
   logic             scheme_err;
   logic [CNT_W-1:0] sym_count;
   logic [1:0]       scheme_out;

   demod_sequencer #(
      .DETECT_CYC (DETECT_CYC),
      .MAX_SYMS   (MAX_SYMS),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .GUARD_CYC  (GUARD_CYC),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .carrier     (carrier),
      .demod_flag  (demod_flag),
      .demod_ctg   (demod_ctg),
      .demod_scheme(demod_scheme),
      .working     (working),
      .bit_data    (bit_data),
      .bit_valid   (bit_valid),
      .bit_ready   (bit_ready),
      .busy        (busy),
      .sym_count   (sym_count),
      .scheme_out  (scheme_out),
      .done        (done),
      .err_timeout (err_timeout),
      .overflow    (overflow),
      .scheme_err  (scheme_err)
   );

   always #5 clock = ~clock;

   int tests     = 0;
   int fails     = 0;
   int done_cnt  = 0;
   int tmo_cnt   = 0;
   int stray_tmo = 0;
   int serr_cnt  = 0;
   int bits_out  = 0;
   bit exp_q[$];

   typedef struct {
      int         nflags;
      int         gap;
      logic [7:0] ctg;       // bit i%8 is the decision of flag i
      bit         ready;     // bit_ready while flags are sent
      int         ready_at;  // flag index at which bit_ready rises
      bit         abort;     // drop enable together with the last flag
      int         exp_sym;
      int         exp_tmo;
      int         exp_ovf;
      int         exp_bits;
   } vec_t;

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Outputs sampled on the falling edge; inputs only change just after rising edges.
   always @(negedge clock) begin
      if (!reset) begin
         if (done) done_cnt++;
         if (done && err_timeout) tmo_cnt++;
         if (err_timeout && !done) stray_tmo++;
         if (scheme_err) serr_cnt++;
         if (bit_valid && bit_ready) begin
            bits_out++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_bit: got %0d, expected no bit", bit_data);
            end else begin
               check("bit_data", int'(bit_data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Model: FIFO occupancy equals the scoreboard depth; a pop this cycle frees a slot.
   function automatic bit keep();
      return (exp_q.size() < FIFO_DEPTH) || (bit_ready && exp_q.size() > 0);
   endfunction

   task automatic open_session(output int lat);
      carrier = 1'b1;
      lat     = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (working) begin
            lat = i;
            break;
         end
      end
      carrier = 1'b0;
   endtask

   task automatic send_flag(input logic ctg, input logic [1:0] sch, input bit drop_en,
                            input bit expect_keep);
      if (expect_keep) exp_q.push_back(ctg);
      demod_flag   = 1'b1;
      demod_ctg    = ctg;
      demod_scheme = sch;
      if (drop_en) enable = 1'b0;
      tick();
      demod_flag = 1'b0;
      demod_ctg  = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_cnt == d0 && n < int'(TIMEOUT_CYC) + 300) begin
         tick();
         n++;
      end
      check(name, done_cnt - d0, 1);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (busy && g < 50) begin
         tick();
         g++;
      end
      check(name, g, GUARD_CYC);
   endtask

   task automatic run_vec(input vec_t v);
      int lat, d0, t0, b0;
      enable    = 1'b1;
      bit_ready = v.ready;
      open_session(lat);
      check("open_latency", lat, DETECT_CYC);
      check("open_sym_clear", int'(sym_count), 0);
      check("open_ovf_clear", int'(overflow), 0);
      d0 = done_cnt;
      t0 = tmo_cnt;
      b0 = bits_out;
      for (int i = 0; i < v.nflags; i++) begin
         repeat (v.gap - 1) tick();
         if (i == v.ready_at) bit_ready = 1'b1;
         send_flag(v.ctg[i % 8], 2'd2, v.abort && (i == v.nflags - 1), keep());
      end
      if (v.abort) check("abort_working", int'(working), 0);
      bit_ready = 1'b1;
      wait_done(d0, "session_done");
      check("sym_count", int'(sym_count), v.exp_sym);
      check("err_timeout", tmo_cnt - t0, v.exp_tmo);
      check("overflow", int'(overflow), v.exp_ovf);
      check("bits_out", bits_out - b0, v.exp_bits);
      check("scoreboard_empty", exp_q.size(), 0);
      check("scheme_out", int'(scheme_out), 2);
      wait_idle("guard_len");
   endtask

   initial begin
      vec_t vecs[5];
      int   lat, d0, s0, b0, exp_sessions;
      // T4: overflow with ready low, then drain 1,1,0,1 after abort.
      vecs[0] = '{nflags:6, gap:3, ctg:8'b0000_1011, ready:1'b0, ready_at:99, abort:1'b1,
                  exp_sym:6, exp_tmo:0, exp_ovf:1, exp_bits:4};
      // T5: enable dropped with the third flag; that flag is still captured.
      vecs[1] = '{nflags:3, gap:4, ctg:8'b0000_0101, ready:1'b1, ready_at:99, abort:1'b1,
                  exp_sym:3, exp_tmo:0, exp_ovf:0, exp_bits:3};
      // T3: five flags then silence -> timeout close.
      vecs[2] = '{nflags:5, gap:7, ctg:8'b0001_0110, ready:1'b1, ready_at:99, abort:1'b0,
                  exp_sym:5, exp_tmo:1, exp_ovf:0, exp_bits:5};
      // T1: full 64-symbol session, alternating bits.
      vecs[3] = '{nflags:64, gap:10, ctg:8'b0101_0101, ready:1'b1, ready_at:99, abort:1'b0,
                  exp_sym:64, exp_tmo:0, exp_ovf:0, exp_bits:64};
      // Back-to-back flags into a full FIFO while it is being popped.
      vecs[4] = '{nflags:7, gap:1, ctg:8'b0110_1001, ready:1'b0, ready_at:4, abort:1'b1,
                  exp_sym:7, exp_tmo:0, exp_ovf:0, exp_bits:7};

      reset        = 1'b1;
      enable       = 1'b0;
      carrier      = 1'b0;
      demod_flag   = 1'b0;
      demod_ctg    = 1'b0;
      demod_scheme = 2'd0;
      bit_ready    = 1'b0;
      exp_sessions = 0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_working", int'(working), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_sym_count", int'(sym_count), 0);
      check("rst_flags", int'({done, err_timeout, overflow, scheme_err, bit_data}), 0);
      check("rst_scheme_out", int'(scheme_out), 0);
      reset = 1'b0;
      tick();

      // T2: a 19-cycle burst does not qualify; the next 20-cycle burst does.
      enable  = 1'b1;
      carrier = 1'b1;
      repeat (19) tick();
      check("t2_first_burst", int'(working), 0);
      carrier = 1'b0;
      tick();
      carrier = 1'b1;
      repeat (19) tick();
      check("t2_not_yet", int'(working), 0);
      tick();
      check("t2_open", int'(working), 1);
      carrier = 1'b0;
      d0      = done_cnt;
      enable  = 1'b0;
      wait_done(d0, "t2_done");
      exp_sessions++;
      check("t2_sym_count", int'(sym_count), 0);
      wait_idle("t2_guard_len");

      for (int k = 0; k < 5; k++) begin
         run_vec(vecs[k]);
         exp_sessions++;
      end

      // Asynchronous reset in the middle of RUN.
      enable    = 1'b1;
      bit_ready = 1'b0;
      open_session(lat);
      send_flag(1'b1, 2'd2, 1'b0, keep());
      send_flag(1'b0, 2'd2, 1'b0, keep());
      check("mid_pre_valid", int'(bit_valid), 1);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      check("mid_working", int'(working), 0);
      check("mid_busy", int'(busy), 0);
      check("mid_bit_valid", int'(bit_valid), 0);
      check("mid_sym_count", int'(sym_count), 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      tick();
      check("mid_no_done", done_cnt - d0, 0);

      // T6: scheme change at the third flag.
      enable    = 1'b1;
      bit_ready = 1'b1;
      open_session(lat);
      d0 = done_cnt;
      s0 = serr_cnt;
      b0 = bits_out;
      check("t6_empty_before", int'(bit_valid), 0);
      send_flag(1'b1, 2'd2, 1'b0, keep());
      check("flag_to_valid", int'(bit_valid), 1);
      send_flag(1'b0, 2'd2, 1'b0, keep());
`ifdef DEMOD_SEQ_SCHEME_LOCK_EN
      send_flag(1'b1, 2'd1, 1'b0, 1'b0);
      enable = 1'b0;
      wait_done(d0, "t6_done");
      check("t6_sym_count", int'(sym_count), 2);
      check("t6_scheme_err", serr_cnt - s0, 1);
      check("t6_bits", bits_out - b0, 2);
`else
      send_flag(1'b1, 2'd1, 1'b0, keep());
      enable = 1'b0;
      wait_done(d0, "t6_done");
      check("t6_sym_count", int'(sym_count), 3);
      check("t6_scheme_err", serr_cnt - s0, 0);
      check("t6_bits", bits_out - b0, 3);
`endif
      exp_sessions++;
      check("t6_scheme_out", int'(scheme_out), 2);
      check("t6_scoreboard_empty", exp_q.size(), 0);
      wait_idle("t6_guard_len");

      check("stray_err_timeout", stray_tmo, 0);
      check("done_total", done_cnt, exp_sessions);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
